ccu_operation_sequencer: RTL
============================

// Module: ccu_operation_sequencer
// PURPOSE
//  Control FSM of the CentralControlUnit. Polls PS-written control registers (start, loaded flags, sizes).
//  Sequences the KAN datapath through btch_size iterations, counts progress and timers.
//  Writes status/progress/done back through the CCU register file enables.
//  Sits between the CCU register file and the datapath iteration handshake.
// PARAMETERS
//  CNT_WIDTH     32  width of progress/timer counters (matches 32-bit registers)
//  BTCH_WIDTH     8  width of btch_size
// PORTS
//  clk                   in   1   clock
//  rst                   in   1   sync reset, active-high
//  operation_start_rd    in   1   PS start flag
//  data/grid/scle/wght_loaded_rd  in  1 each  buffer-loaded flags
//  btch_size_rd          in   8   iterations per operation
//  rslt_size_rd          in   32  result beats per iteration
//  interrupt_soft/abort/error  in  1 each  PS interrupts (level)
//  iter_valid            out  1   request datapath iteration
//  iter_ready            in   1   datapath accepts iteration
//  rslt_beat             in   1   one result beat transmitted
//  rslt_tlast            in   1   last result beat of iteration transmitted
//  dp_error              in   1   datapath fault (level)
//  rw_op_str_reg_en / operation_start_wr      out 1/1   clear start flag
//  rw_op_dne_reg_en / operation_done_wr       out 1/1   write done flag
//  wo_reg_en / wo_reg_rst                     out 1/1   progress/timer register update / clear
//  operation_status_{idle,busy,error,locked,valid}_wr  out  1 each
//  operation_progress_rslt_wr/_iter_wr, iteration_timer_wr/_latency_wr, operation_timer_wr/_latency_wr  out 32 each
// BEHAVIOUR
//  States: IDLE, WAIT_LD, STR, ISSUE, RUN, DONE, ERROR. Reset -> IDLE. All outputs 0 except status_idle=1.
//  IDLE:    status_idle=1. operation_start_rd=1 -> WAIT_LD.
//  WAIT_LD: status_busy=1. All four loaded flags=1 -> STR.
//           operation_start_rd dropping -> IDLE.
//  STR (1 cycle): wo_reg_rst=1, rw_op_str_reg_en=1 with operation_start_wr=0, rw_op_dne_reg_en=1 with done_wr=0.
//           Clears all counters. btch_size_rd latched; btch_size==0 -> DONE, else -> ISSUE.
//  ISSUE:   iter_valid=1, held until iter_ready (AXIS-style, no retraction) -> RUN. iteration_timer cleared.
//  RUN:     rslt_beat increments progress_rslt (saturates at 2^32-1).
//           rslt_tlast: progress_iter+1, iteration_latency<=iteration_timer+1, wo_reg_en=1 that cycle.
//           progress_iter==btch -> DONE, else -> ISSUE.
//           Simultaneous rslt_beat+rslt_tlast: both counted, same cycle.
//  DONE (1 cycle): rw_op_dne_reg_en=1, done_wr=1, operation_latency<=operation_timer+1, wo_reg_en=1.
//           status_valid set, sticky until next STR. -> IDLE.
//  wo_reg_en also pulses every cycle of ISSUE/RUN so timers are live-visible to PS.
//  Abort: interrupt_abort in WAIT_LD..RUN -> IDLE next cycle.
//           iter_valid drops, done not written, status_valid cleared.
//  Error: dp_error or interrupt_error in any non-IDLE state -> ERROR. Error has priority over abort and tlast.
//           ERROR: status_error=1, status_locked=1, iter_valid=0. Exits to IDLE only on interrupt_soft.
//  status_locked=1 also in STR..DONE (PS must not rewrite sizes).
//  status_busy=1 in WAIT_LD..DONE. Exactly one of idle/busy/error asserted per cycle.
//  Counters saturate, never wrap. rst mid-operation: immediate IDLE, counters zero, no done write.
//  Sizes are read only in STR; later PS writes do not affect the running operation.
// CONFIGURATION
//  CCU_TIMERS_EN defined: iteration/operation timers count clk cycles.
//    Iteration timer from ISSUE entry; operation timer from STR.
//  Undefined: timer/latency outputs tied to 0, counter logic removed; progress counters unaffected.
// STRUCTURE
//  Shared package header: FSM state encoding (FSM_IDLE..FSM_ERROR, FSM_STR shared with register file),
//    status bit masks, CNT_WIDTH.
//  One sub-module: ccu_sat_counter (clear, inc, saturating, width param) used for all six counters.
// TESTING
//  Flags all 1, btch=3, rslt=4, start=1 -> one str clear, 3 iter_valid handshakes.
//    progress_iter=3, progress_rslt=12, done_wr=1 pulse, status_valid=1.
//  btch=0, start=1 -> STR then DONE in 2 cycles, no iter_valid, progress=0.
//  iter_ready held 0 for 5 cycles -> iter_valid stays 1; with timers, iteration_latency >= 6.
//  interrupt_abort mid-RUN (iter 2 of 4) -> IDLE next cycle, no done write, status_idle=1.
//  dp_error together with rslt_tlast -> ERROR, locked=1, iter count not advanced.
//    interrupt_soft -> IDLE.
//  rst asserted in RUN -> all outputs at reset values next cycle.
//    Restart completes normally with counters from 0.

Source files
------------

// File: rtl/ccu_operation_sequencer_pkg.sv
// rtl/ccu_operation_sequencer_pkg.sv - shared types and constants for the CCU operation sequencer
//
// Purpose: FSM state encoding (FSM_STR is also decoded by the CCU register
//          file), status bit masks and the default counter width.
// Ports:   none (package).
package ccu_operation_sequencer_pkg;

  localparam int CCU_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    FSM_IDLE    = 3'd0,
    FSM_WAIT_LD = 3'd1,
    FSM_STR     = 3'd2,
    FSM_ISSUE   = 3'd3,
    FSM_RUN     = 3'd4,
    FSM_DONE    = 3'd5,
    FSM_ERROR   = 3'd6
  } fsm_state_e;

  // Bit positions inside the internal status vector.
  localparam logic [4:0] STATUS_IDLE_M   = 5'b00001;
  localparam logic [4:0] STATUS_BUSY_M   = 5'b00010;
  localparam logic [4:0] STATUS_ERROR_M  = 5'b00100;
  localparam logic [4:0] STATUS_LOCKED_M = 5'b01000;
  localparam logic [4:0] STATUS_VALID_M  = 5'b10000;

endpackage

// File: rtl/ccu_sat_counter.sv
// rtl/ccu_sat_counter.sv - saturating counter with clear and load
//
// Purpose: counter that never wraps; clear beats load beats increment.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero the count
//   inc             count up by one (holds at all-ones)
//   load, load_val  overwrite the count
//   count           current value
module ccu_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ccu_operation_sequencer.sv
// rtl/ccu_operation_sequencer.sv - CCU control FSM sequencing KAN datapath iterations
//
// Purpose: polls PS control flags, runs btch_size datapath iterations, keeps
//          progress counters and (optionally) cycle timers, and writes
//          status/progress/done back through the register-file enables.
// Build option: CCU_TIMERS_EN enables iteration/operation timers; without it
//          the timer and latency outputs are tied to zero.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   operation_start_rd, *_loaded_rd   PS start and buffer-loaded flags
//   btch_size_rd, rslt_size_rd        operation sizes (sampled in STR)
//   interrupt_soft/abort/error        PS interrupts (level)
//   iter_valid / iter_ready           datapath iteration handshake
//   rslt_beat, rslt_tlast, dp_error   datapath result progress and fault
//   rw_op_str_reg_en, operation_start_wr  start-flag clear
//   rw_op_dne_reg_en, operation_done_wr   done-flag write
//   wo_reg_en, wo_reg_rst             progress/timer register update / clear
//   operation_status_*_wr             status bits
//   operation_progress_*_wr, *_timer_wr, *_latency_wr  32-bit counters
module ccu_operation_sequencer
  import ccu_operation_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH  = CCU_CNT_WIDTH,
  parameter int BTCH_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  operation_start_rd,
  input  logic                  data_loaded_rd,
  input  logic                  grid_loaded_rd,
  input  logic                  scle_loaded_rd,
  input  logic                  wght_loaded_rd,
  input  logic [BTCH_WIDTH-1:0] btch_size_rd,
  input  logic [CNT_WIDTH-1:0]  rslt_size_rd,
  input  logic                  interrupt_soft,
  input  logic                  interrupt_abort,
  input  logic                  interrupt_error,
  output logic                  iter_valid,
  input  logic                  iter_ready,
  input  logic                  rslt_beat,
  input  logic                  rslt_tlast,
  input  logic                  dp_error,
  output logic                  rw_op_str_reg_en,
  output logic                  operation_start_wr,
  output logic                  rw_op_dne_reg_en,
  output logic                  operation_done_wr,
  output logic                  wo_reg_en,
  output logic                  wo_reg_rst,
  output logic                  operation_status_idle_wr,
  output logic                  operation_status_busy_wr,
  output logic                  operation_status_error_wr,
  output logic                  operation_status_locked_wr,
  output logic                  operation_status_valid_wr,
  output logic [CNT_WIDTH-1:0]  operation_progress_rslt_wr,
  output logic [CNT_WIDTH-1:0]  operation_progress_iter_wr,
  output logic [CNT_WIDTH-1:0]  iteration_timer_wr,
  output logic [CNT_WIDTH-1:0]  iteration_latency_wr,
  output logic [CNT_WIDTH-1:0]  operation_timer_wr,
  output logic [CNT_WIDTH-1:0]  operation_latency_wr
);

  fsm_state_e            state, next_state;
  logic [BTCH_WIDTH-1:0] btch_q;
  logic                  valid_q;
  logic [4:0]            status_flags;
  logic                  fault, all_loaded, last_iter;
  logic                  beat_take, tlast_take, done_take, valid_clr;

  // The iteration is framed by rslt_tlast from the datapath; the result size
  // is consumed by the datapath, not by the sequencer.
  logic unused_rslt_size;
  assign unused_rslt_size = ^rslt_size_rd;

  assign fault      = dp_error | interrupt_error;
  assign all_loaded = data_loaded_rd & grid_loaded_rd & scle_loaded_rd & wght_loaded_rd;
  // Decided on the tlast cycle, so compare the count it is about to become.
  assign last_iter  = (operation_progress_iter_wr + CNT_WIDTH'(1)) == CNT_WIDTH'(btch_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FSM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state         = state;
    iter_valid         = 1'b0;
    rw_op_str_reg_en   = 1'b0;
    operation_start_wr = 1'b0;
    rw_op_dne_reg_en   = 1'b0;
    operation_done_wr  = 1'b0;
    wo_reg_en          = 1'b0;
    wo_reg_rst         = 1'b0;
    status_flags       = '0;
    beat_take          = 1'b0;
    tlast_take         = 1'b0;
    done_take          = 1'b0;
    valid_clr          = 1'b0;
    unique case (state)
      FSM_IDLE: begin
        status_flags = STATUS_IDLE_M;
        if (operation_start_rd) next_state = FSM_WAIT_LD;
      end
      FSM_WAIT_LD: begin
        status_flags = STATUS_BUSY_M;
        if (fault) begin
          next_state = FSM_ERROR;
        end else if (interrupt_abort) begin
          next_state = FSM_IDLE;
          valid_clr  = 1'b1;
        end else if (!operation_start_rd) begin
          next_state = FSM_IDLE;
        end else if (all_loaded) begin
          next_state = FSM_STR;
        end
      end
      FSM_STR: begin
        // Clear start flag, clear done flag, zero every counter.
        status_flags     = STATUS_BUSY_M | STATUS_LOCKED_M;
        wo_reg_rst       = 1'b1;
        rw_op_str_reg_en = 1'b1;
        rw_op_dne_reg_en = 1'b1;
        if (fault) begin
          next_state = FSM_ERROR;
        end else if (interrupt_abort) begin
          next_state = FSM_IDLE;
          valid_clr  = 1'b1;
        end else if (btch_size_rd == '0) begin
          next_state = FSM_DONE;
        end else begin
          next_state = FSM_ISSUE;
        end
      end
      FSM_ISSUE: begin
        status_flags = STATUS_BUSY_M | STATUS_LOCKED_M;
        iter_valid   = 1'b1;
        wo_reg_en    = 1'b1;
        if (fault) begin
          next_state = FSM_ERROR;
        end else if (interrupt_abort) begin
          next_state = FSM_IDLE;
          valid_clr  = 1'b1;
        end else if (iter_ready) begin
          next_state = FSM_RUN;
        end
      end
      FSM_RUN: begin
        status_flags = STATUS_BUSY_M | STATUS_LOCKED_M;
        wo_reg_en    = 1'b1;
        // Fault and abort both win over result progress in the same cycle.
        if (fault) begin
          next_state = FSM_ERROR;
        end else if (interrupt_abort) begin
          next_state = FSM_IDLE;
          valid_clr  = 1'b1;
        end else begin
          beat_take  = rslt_beat;
          tlast_take = rslt_tlast;
          if (rslt_tlast) next_state = last_iter ? FSM_DONE : FSM_ISSUE;
        end
      end
      FSM_DONE: begin
        status_flags = STATUS_BUSY_M | STATUS_LOCKED_M;
        wo_reg_en    = 1'b1;
        if (fault) begin
          next_state = FSM_ERROR;
        end else begin
          done_take         = 1'b1;
          rw_op_dne_reg_en  = 1'b1;
          operation_done_wr = 1'b1;
          next_state        = FSM_IDLE;
        end
      end
      FSM_ERROR: begin
        status_flags = STATUS_ERROR_M | STATUS_LOCKED_M;
        if (interrupt_soft) next_state = FSM_IDLE;
      end
      default: next_state = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btch_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (state == FSM_STR) btch_q <= btch_size_rd;
      if (wo_reg_rst || valid_clr) begin
        valid_q <= 1'b0;
      end else if (done_take) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign operation_status_idle_wr   = |(status_flags & STATUS_IDLE_M);
  assign operation_status_busy_wr   = |(status_flags & STATUS_BUSY_M);
  assign operation_status_error_wr  = |(status_flags & STATUS_ERROR_M);
  assign operation_status_locked_wr = |(status_flags & STATUS_LOCKED_M);
  assign operation_status_valid_wr  = valid_q;

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_prog_rslt (
    .clk(clk), .rst(rst), .clear(wo_reg_rst), .inc(beat_take),
    .load(1'b0), .load_val('0), .count(operation_progress_rslt_wr)
  );

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_prog_iter (
    .clk(clk), .rst(rst), .clear(wo_reg_rst), .inc(tlast_take),
    .load(1'b0), .load_val('0), .count(operation_progress_iter_wr)
  );

`ifdef CCU_TIMERS_EN
  logic                 iter_tmr_clr, iter_tmr_inc, op_tmr_inc;
  logic [CNT_WIDTH-1:0] iter_lat_val, op_lat_val;

  // Iteration timer restarts on every entry into ISSUE and runs through RUN.
  assign iter_tmr_clr = wo_reg_rst | ((next_state == FSM_ISSUE) && (state != FSM_ISSUE));
  assign iter_tmr_inc = (state == FSM_ISSUE) || (state == FSM_RUN);
  assign op_tmr_inc   = (state == FSM_ISSUE) || (state == FSM_RUN) || (state == FSM_DONE);
  // Latency includes the closing cycle itself.
  assign iter_lat_val = (iteration_timer_wr == '1) ? iteration_timer_wr
                                                   : iteration_timer_wr + CNT_WIDTH'(1);
  assign op_lat_val   = (operation_timer_wr == '1) ? operation_timer_wr
                                                   : operation_timer_wr + CNT_WIDTH'(1);

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_iter_tmr (
    .clk(clk), .rst(rst), .clear(iter_tmr_clr), .inc(iter_tmr_inc),
    .load(1'b0), .load_val('0), .count(iteration_timer_wr)
  );

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_iter_lat (
    .clk(clk), .rst(rst), .clear(wo_reg_rst), .inc(1'b0),
    .load(tlast_take), .load_val(iter_lat_val), .count(iteration_latency_wr)
  );

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_op_tmr (
    .clk(clk), .rst(rst), .clear(wo_reg_rst), .inc(op_tmr_inc),
    .load(1'b0), .load_val('0), .count(operation_timer_wr)
  );

  ccu_sat_counter #(.WIDTH(CNT_WIDTH)) u_op_lat (
    .clk(clk), .rst(rst), .clear(wo_reg_rst), .inc(1'b0),
    .load(done_take), .load_val(op_lat_val), .count(operation_latency_wr)
  );
`else
  assign iteration_timer_wr   = '0;
  assign iteration_latency_wr = '0;
  assign operation_timer_wr   = '0;
  assign operation_latency_wr = '0;
`endif

endmodule
